crossbar_slave_mem: RTL
=======================

Name: crossbar_slave_mem

Overview:
- Clocked single-port memory slave that sits directly downstream of the 2-master/2-slave crossbar on one slave port.
- Consumes the crossbar's slave_x_req/addr/cmd/wdata and returns slave_x_ack/slave_x_rdata after a programmable latency.
- Serves as the synthesizable slave model for both crossbar slave ports.
- Handles one transaction at a time, sequenced by an FSM.

Parameters:
- DATA_W, 32, data width; must match crossbar data width.
- ADDR_W, 8, word-index bits; memory depth = 2**ADDR_W words.
- LATENCY, 2, cycles from the accept edge to the ack cycle; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request from crossbar; held high with addr/cmd/wdata stable until ack is seen.
- addr  input  32  byte address; word index = addr[ADDR_W+1:2]. addr[31], addr[1:0] and the remaining upper bits are ignored, so the memory aliases.
- cmd  input  1  1 = write, 0 = read.
- wdata  input  DATA_W  write data.
- ack  output  1  single-cycle completion pulse.
- rdata  output  DATA_W  read data; valid only while ack=1 on a read, 0 at all other times.
- busy  output  1  high while a transaction is in flight (or a clear sweep is running); informational only.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, ack=0, rdata=0, busy=0, latency counter=0. Memory contents are not reset unless the optional feature is compiled in.
- FSM states: IDLE, WAIT, ACK, plus CLEAR when the optional feature is compiled in.
- IDLE:
  - If req=1 at a rising edge, the transaction is accepted at that edge (the accept edge): index, cmd and wdata are captured, counter loads LATENCY-1, busy=1.
  - Write: the memory word is written at the accept edge.
  - Read: the memory word is read at the accept edge into a holding register.
  - Next state is ACK if LATENCY=1, otherwise WAIT.
- WAIT:
  - Counter decrements each cycle. When the counter reaches 1, the next state is ACK.
  - If req drops while in WAIT, the transaction is aborted: return to IDLE with no ack and busy=0. A write that was already committed at the accept edge stays committed.
- ACK:
  - ack=1 for exactly one cycle.
  - Read: rdata = held word. Write: rdata = 0.
  - Next state is IDLE, busy=0, rdata returns to 0.
  - ack is issued even if req dropped during the ACK cycle itself.
- Timing: ack is high in the LATENCY-th cycle after the accept edge. Minimum spacing between accept edges is LATENCY+1 cycles.
- Back-to-back transactions: req still high in the first IDLE cycle after ACK is treated as a new transaction. The requester must drop req on the edge after ack unless it is issuing a new request.
- Read-after-write to the same word returns the new data.
- Misaligned addr[1:0] is ignored, with no error signalled.
- LATENCY outside 1..15 is a configuration error; a simulation-only check fires $error at time 0.

Optional Feature:
- Macro: CROSSBAR_SLAVE_MEM_CLEAR_EN.
- Defined:
  - On reset release the FSM enters CLEAR, with busy=1.
  - The sweep writes 0 to word 0 through word 2**ADDR_W-1, one word per cycle, then enters IDLE.
  - req is ignored during CLEAR: nothing is accepted and ack stays 0. A held req is accepted in the first IDLE cycle.
  - Reasserting rst_n low mid-sweep restarts the sweep from word 0.
- Undefined: there is no CLEAR state, the FSM starts in IDLE, and memory contents are X until written.

Test Plan:
- Write then read, LATENCY=2: write addr=0x0000_0010, wdata=0xDEAD_BEEF, accepted at edge 0 -> ack high in cycle 2 with rdata=0. Read of the same address -> ack 2 cycles after its accept edge with rdata=0xDEAD_BEEF, and rdata=0 in the next cycle.
- Aliasing: write addr=0x8000_0404, wdata=0x1234_5678 (ADDR_W=8, index 1) -> read addr=0x0000_0004 returns 0x1234_5678. Read addr=0x0000_0007 also returns 0x1234_5678.
- Abort, LATENCY=4: read accepted, then req dropped in WAIT cycle 2 -> no ack, busy=0 by cycle 3. A following write is accepted normally, with ack 4 cycles after its accept edge.
- Reset mid-operation: assert rst_n low while in WAIT -> ack=0, rdata=0, busy=0 immediately (asynchronously). After release, a held req is accepted on the first edge and a fresh ack follows LATENCY cycles later.
- Back-to-back, LATENCY=1: req held high across two reads with different addresses -> acks in cycles 1 and 3, each carrying its own word. There is no ack in cycle 2.
- With CROSSBAR_SLAVE_MEM_CLEAR_EN defined and ADDR_W=4, req held high from reset release:
  - busy=1 for 16 cycles, with no ack during that time.
  - The request is then accepted; a read of any address returns 0.

Source files
------------

// File: rtl/crossbar_slave_mem.sv
// rtl/crossbar_slave_mem.sv - single-port memory slave for one crossbar slave port
//
// Accepts one request at a time from the crossbar and acknowledges it
// LATENCY cycles after the accept edge. Writes land in memory on the accept
// edge. Reads sample memory on the accept edge into a holding register.
//
// Parameters:
//   DATA_W   data width (matches the crossbar)
//   ADDR_W   word-index bits, depth = 2**ADDR_W words
//   LATENCY  accept edge to ack cycle, 1..15
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   req    request, held with addr/cmd/wdata until ack
//   addr   byte address, word index = addr[ADDR_W+1:2], other bits alias
//   cmd    1 = write, 0 = read
//   wdata  write data
//   ack    single-cycle completion pulse
//   rdata  read data while ack is high on a read, otherwise 0
//   busy   transaction in flight or clear sweep running
//
// Optional feature macro: CROSSBAR_SLAVE_MEM_CLEAR_EN
//   When defined, reset release starts a sweep that zeroes every word,
//   one per cycle, before the first request can be accepted.

module crossbar_slave_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [31:0]       addr,
    input  logic              cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
            $error("crossbar_slave_mem: LATENCY must be within 1..15");
        end
    endgenerate

`ifdef CROSSBAR_SLAVE_MEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] hold_q;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_nxt;
    logic              cmd_q;
    logic              accept;
    state_t            state_q;
    state_t            state_nxt;

    // Upper address bits and the byte offset are deliberately discarded.
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign idx = addr[ADDR_W+1:2];

`ifdef CROSSBAR_SLAVE_MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_idx_q <= '0;
        end else if (state_q == S_CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // rst_n gate keeps a request held during reset from writing memory.
                if (req && rst_n) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_nxt = S_ACK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
`ifdef CROSSBAR_SLAVE_MEM_CLEAR_EN
            S_CLEAR: begin
                if (&clr_idx_q) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (accept) begin
                cmd_q <= cmd;
            end
        end
    end

    // Memory array and read holding register carry no reset.
    always_ff @(posedge clk) begin
        if (accept && cmd) begin
            mem[idx] <= wdata;
        end
        if (accept && !cmd) begin
            hold_q <= mem[idx];
        end
`ifdef CROSSBAR_SLAVE_MEM_CLEAR_EN
        if (state_q == S_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end
`endif
    end

    assign ack   = (state_q == S_ACK);
    assign rdata = ((state_q == S_ACK) && !cmd_q) ? hold_q : '0;
    assign busy  = (state_q != S_IDLE);

endmodule
